// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for pipe_hazard_ctrl: ID/EX hazard inputs (driven by the
// pipeline, modport master) and the sequencing controls (driven by the controller, modport slave).
interface pipe_hazard_ctrl_if #(
    parameter int RADDR_W = 5
);
    logic [26:0]        id_instr;
    logic [RADDR_W-1:0] id_rs1;
    logic [RADDR_W-1:0] id_rs2;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [26:0]        ex_instr;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_taken;

    logic               pc_en;
    logic               if_id_en;
    logic               if_id_flush;
    logic               id_ex_bubble;
    logic               halted;
    logic [1:0]         state;

    modport master (
        output id_instr, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_instr, ex_rd, ex_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, state
    );

    modport slave (
        input  id_instr, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_instr, ex_rd, ex_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, halted, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flush, HALT drain.
// Optional perf counters (stall_count/flush_count) built only with HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT     = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int RADDR_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0]          stall_count,
    output logic [15:0]          flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam logic [4:0] OP_LDST    = 5'b11111;
    localparam logic [4:0] OP_HALT    = 5'b10000;
    localparam logic [2:0] STALL_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    function automatic logic is_load(input logic [26:0] instr);
        return (instr[26:22] == OP_LDST) &&
               ((instr[21:20] == 2'b00) || (instr[21:20] == 2'b10));
    endfunction

    function automatic logic is_halt(input logic [26:0] instr);
        return instr[26:22] == OP_HALT;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_bubble_s;
    logic load_use_s, stall_s, taken_acc_s;

    logic unused_s;
    assign unused_s = ^{bus.id_instr[21:0], bus.ex_instr[19:0]};

    // Load-use hazard between the EX load and the ID sources (r0 is not special)
    always_comb begin
        load_use_s = is_load(bus.ex_instr) &&
                     ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));
    end

    // Next-state, counter and combinational control outputs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        stall_s        = 1'b0;
        taken_acc_s    = 1'b0;
        if (!rst) begin
            state_d        = ST_RUN;
            cnt_d          = 3'd0;
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.ex_taken) begin
                        if_id_flush_s  = 1'b1;
                        id_ex_bubble_s = 1'b1;
                        taken_acc_s    = 1'b1;
                    end else if (load_use_s) begin
                        pc_en_s        = 1'b0;
                        if_id_en_s     = 1'b0;
                        id_ex_bubble_s = 1'b1;
                        stall_s        = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = STALL_INIT;
                        end else begin
                            cnt_d = 3'd0;
                        end
                    end else if (is_halt(bus.id_instr)) begin
                        pc_en_s       = 1'b0;
                        if_id_en_s    = 1'b0;
                        if_id_flush_s = 1'b1;
                        state_d       = ST_DRAIN;
                        cnt_d         = DRAIN_INIT;
                    end else begin
                        cnt_d = 3'd0;
                    end
                end
                ST_STALL: begin
                    // The detect cycle in RUN is the first stall cycle, so leave one early
                    pc_en_s        = 1'b0;
                    if_id_en_s     = 1'b0;
                    id_ex_bubble_s = 1'b1;
                    stall_s        = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_DRAIN: begin
                    pc_en_s        = 1'b0;
                    if_id_en_s     = 1'b0;
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    if (bus.ex_taken) begin
                        // An older branch resolved taken: the HALT was wrong-path
                        pc_en_s     = 1'b1;
                        taken_acc_s = 1'b1;
                        state_d     = ST_RUN;
                        cnt_d       = 3'd0;
                    end else if (cnt_q == 3'd0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_HALTED: begin
                    pc_en_s        = 1'b0;
                    if_id_en_s     = 1'b0;
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end
                default: begin
                    state_d        = ST_RUN;
                    cnt_d          = 3'd0;
                    pc_en_s        = 1'b0;
                    if_id_en_s     = 1'b0;
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end
            endcase
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_en        = pc_en_s;
    assign bus.if_id_en     = if_id_en_s;
    assign bus.if_id_flush  = if_id_flush_s;
    assign bus.id_ex_bubble = id_ex_bubble_s;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.state        = state_q;

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_count_q;
    logic [15:0] flush_count_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            if (stall_s) begin
                stall_count_q <= sat_inc(stall_count_q);
            end
            if (taken_acc_s) begin
                flush_count_q <= sat_inc(flush_count_q);
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    logic unused_perf_s;
    assign unused_perf_s = stall_s ^ taken_acc_s;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 27-bit, 5-bit-opcode pipelined core. It sits beside the IF/ID/EX pipeline registers and drives PC enable, IF/ID enable/flush and ID/EX bubble insertion. It detects load-use hazards, flushes wrong-path instructions on taken BEQ/BNEQ/JMP, and drains the pipeline after HALT.

## Interface
- LOAD_LAT, 1: stall cycles inserted per load-use hazard (1..7).
- DRAIN_CYCLES, 3: cycles spent in DRAIN after HALT leaves ID (1..7).
- RADDR_W, 5: register address width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- id_instr  in  27  instruction in ID; opcode [26:22], LD/ST subtype [21:20].
- id_rs1, id_rs2  in  RADDR_W  source registers of the ID instruction.
- id_rs1_used, id_rs2_used  in  1  source actually read (decoder-qualified).
- ex_instr  in  27  instruction in EX.
- ex_rd  in  RADDR_W  destination register of the EX instruction.
- ex_taken  in  1  EX resolved a taken BEQ/BNEQ or JMP this cycle.
- pc_en  out  1  PC may advance or load.
- if_id_en  out  1  IF/ID register captures.
- if_id_flush  out  1  IF/ID loads NOP (overrides if_id_en).
- id_ex_bubble  out  1  ID/EX loads NOP.
- halted  out  1  core stopped.
- state  out  2  RUN=0, STALL=1, DRAIN=2, HALTED=3.
- stall_count, flush_count  out  16  perf counters (only with macro; see Configuration).

## Operation
- Load in EX: ex_instr[26:22]=5'b11111 and ex_instr[21:20] is 2'b00 (LDB) or 2'b10 (LDW). STB/STW never stall.
- Load-use: load in EX and ((id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd)). All registers are compared, r0 included.
- HALT in ID: id_instr[26:22]=5'b10000.
- Priority in RUN: ex_taken > load-use > HALT.
- RUN, ex_taken: if_id_flush=1, id_ex_bubble=1, pc_en=1. Stay RUN.
- RUN, load-use: pc_en=0, if_id_en=0, id_ex_bubble=1. Go to STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1; otherwise stay RUN.
- RUN, HALT: pc_en=0, if_id_flush=1, id_ex_bubble=0 (HALT advances into EX). Go to DRAIN with cnt=DRAIN_CYCLES-1.
- RUN, otherwise: pc_en=1, if_id_en=1, flush/bubble=0.
- STALL: outputs as load-use. Hazard inputs and ex_taken are ignored (EX holds a bubble). cnt decrements; at cnt==0, next state is RUN.
- DRAIN: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1.
  - ex_taken (older branch; HALT was wrong-path): pc_en=1, go to RUN.
  - Otherwise cnt decrements; at cnt==0, next state is HALTED.
- HALTED: halted=1, pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1. All inputs ignored. Only rst exits.

## Timing
- All state and counter updates happen on the rising clk edge. Control outputs are combinational from state plus current inputs, so hazard response occurs in the same cycle.
- While rst=0 (sampled), and in the cycle after reset: state=RUN, cnt=0, perf counters=0, halted=0.
- Control outputs are forced while rst=0: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1.
- Load-use detected at cycle N: stall asserted for cycles N..N+LOAD_LAT-1. Normal flow resumes at N+LOAD_LAT.
- HALT in ID at cycle N: pc_en=0 from cycle N. DRAIN occupies cycles N+1..N+DRAIN_CYCLES. halted=1 from cycle N+DRAIN_CYCLES+1.
- ex_taken flush takes effect on the same edge; there are no extra flush cycles.
- rst=0 in any state returns to RUN on the next edge, aborting STALL, DRAIN or HALTED.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - stall_count increments once per cycle in which the stall outputs are asserted.
  - flush_count increments once per accepted ex_taken.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by rst.
- Not defined: the stall_count and flush_count ports are absent and no counter logic is built.

## Test plan
- Reset: hold rst=0 for 3 cycles -> pc_en=0, if_id_flush=1, id_ex_bubble=1, halted=0, state=0. Release -> pc_en=1, if_id_en=1 on the first cycle after release.
- Load-use: ex_instr=LDW (11111,10), ex_rd=3, id_rs1=3, id_rs1_used=1 -> exactly 1 stall cycle. With LOAD_LAT=3 -> 3 stall cycles, state=1 for the last 2.
- No false stall: ex_instr=STW (11111,11), or LDB with id_rs1_used=0 -> pc_en stays 1.
- Simultaneous events: ex_taken=1 with a load-use match and HALT in ID -> if_id_flush=1, id_ex_bubble=1, pc_en=1, state remains RUN.
- HALT: HALT in ID at cycle 20 with DRAIN_CYCLES=3 -> pc_en=0 from 20, state=2 in cycles 21-23, halted=1 from cycle 24. Repeat with ex_taken=1 at cycle 22 -> state=0 and pc_en=1 at cycle 23, halted never asserted.
- Perf (macro on): 5 load-use hazards and 2 taken branches -> stall_count=5, flush_count=2. Preload near saturation -> holds at 16'hFFFF.
